// File: rtl/sort_sequencer_if.sv
// Control bundle between the shearsort sequencer and its PE mesh.
// Requests (start/hold) flow in; phase/step/round strobes flow out to the PEs.
interface sort_sequencer_if #(
  parameter int LOG2N = 2
);
  logic             i_start;
  logic             i_hold;
  logic             o_busy;
  logic             o_load;
  logic             o_phase;
  logic             o_parity;
  logic             o_step_en;
  logic [LOG2N-1:0] o_step;
  logic [3:0]       o_round;
  logic             o_done;

  modport master (
    output i_start, i_hold,
    input  o_busy, o_load, o_phase, o_parity, o_step_en, o_step, o_round, o_done
  );

  modport slave (
    input  i_start, i_hold,
    output o_busy, o_load, o_phase, o_parity, o_step_en, o_step, o_round, o_done
  );
endinterface

// File: rtl/sort_sequencer.sv
// Shearsort phase sequencer: LOAD, then alternating row/column transposition phases, then DONE.
// Outputs are registered except o_step_en, which i_hold gates combinationally; i_hold freezes ROW/COL.
module sort_sequencer #(
  parameter int N           = 4,
  parameter int SORT_CYCLES = 1,
  parameter int LOG2N       = 2
) (
  input logic             clk,
  input logic             rst,
  sort_sequencer_if.slave bus
);

  localparam int               CW         = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam logic [CW-1:0]    CYC_LAST   = CW'(SORT_CYCLES - 1);
  localparam logic [LOG2N-1:0] STEP_LAST  = LOG2N'(N - 1);
  localparam logic [3:0]       ROUND_LAST = 4'(LOG2N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_COL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [LOG2N-1:0] step_q, step_d;
  logic [3:0]       round_q, round_d;

  logic in_phase;
  logic cyc_last;

  assign in_phase = (state_q == S_ROW) || (state_q == S_COL);
  assign cyc_last = (cyc_q == CYC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        // Counters are held clear here so LOAD always begins from round 0, step 0.
        cyc_d   = '0;
        step_d  = '0;
        round_d = '0;
        if (bus.i_start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ROW;
      end
      S_ROW, S_COL: begin
        if (!bus.i_hold) begin
          if (!cyc_last) begin
            cyc_d = cyc_q + 1'b1;
          end else begin
            cyc_d = '0;
            if (step_q != STEP_LAST) begin
              step_d = step_q + 1'b1;
            end else begin
              step_d = '0;
              if (state_q == S_COL) begin
                state_d = S_ROW;
                round_d = round_q + 4'd1;
              end else if (round_q == ROUND_LAST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_COL;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        step_d  = '0;
        round_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_load    = (state_q == S_LOAD);
  assign bus.o_done    = (state_q == S_DONE);
  assign bus.o_phase   = (state_q == S_COL);
  assign bus.o_parity  = in_phase & step_q[0];
  assign bus.o_step    = in_phase ? step_q : '0;
  assign bus.o_round   = in_phase ? round_q : 4'd0;
  assign bus.o_step_en = in_phase & cyc_last & ~bus.i_hold;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: three configurations checked cycle by cycle against a queue of expected states.
// Directed scenarios (plain, SORT_CYCLES=3, N=8, hold, mid-sort reset, continuous start) then random start/hold.
module tb_sort_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   sel   = 0;
  logic start = 1'b0;
  logic hold  = 1'b0;

  sort_sequencer_if #(.LOG2N(2)) if0 ();
  sort_sequencer_if #(.LOG2N(2)) if1 ();
  sort_sequencer_if #(.LOG2N(3)) if2 ();

  sort_sequencer #(.N(4), .SORT_CYCLES(1), .LOG2N(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
  sort_sequencer #(.N(4), .SORT_CYCLES(3), .LOG2N(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  sort_sequencer #(.N(8), .SORT_CYCLES(1), .LOG2N(3)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.i_start = (sel == 0) && start;
  assign if0.i_hold  = (sel == 0) && hold;
  assign if1.i_start = (sel == 1) && start;
  assign if1.i_hold  = (sel == 1) && hold;
  assign if2.i_start = (sel == 2) && start;
  assign if2.i_hold  = (sel == 2) && hold;

  typedef struct packed {
    logic       busy;
    logic       load;
    logic       phase;
    logic       parity;
    logic [2:0] step;
    logic [3:0] round;
    logic       step_en;
    logic       done;
  } rec_t;

  rec_t obs;
  always_comb begin
    obs = '0;
    case (sel)
      0: begin
        obs.busy = if0.o_busy;   obs.load = if0.o_load;   obs.phase = if0.o_phase;
        obs.parity = if0.o_parity; obs.step = {1'b0, if0.o_step}; obs.round = if0.o_round;
        obs.step_en = if0.o_step_en; obs.done = if0.o_done;
      end
      1: begin
        obs.busy = if1.o_busy;   obs.load = if1.o_load;   obs.phase = if1.o_phase;
        obs.parity = if1.o_parity; obs.step = {1'b0, if1.o_step}; obs.round = if1.o_round;
        obs.step_en = if1.o_step_en; obs.done = if1.o_done;
      end
      default: begin
        obs.busy = if2.o_busy;   obs.load = if2.o_load;   obs.phase = if2.o_phase;
        obs.parity = if2.o_parity; obs.step = if2.o_step; obs.round = if2.o_round;
        obs.step_en = if2.o_step_en; obs.done = if2.o_done;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;
  int n_busy = 0, n_sten = 0, n_load = 0, n_done = 0;
  rec_t q[$];

  function automatic int cfg_n(int s);   return (s == 2) ? 8 : 4; endfunction
  function automatic int cfg_sc(int s);  return (s == 1) ? 3 : 1; endfunction
  function automatic int cfg_lg(int s);  return (s == 2) ? 3 : 2; endfunction

  // Expected per-cycle trace of one whole sort for the selected configuration.
  task automatic push_sort();
    rec_t r;
    int n  = cfg_n(sel);
    int sc = cfg_sc(sel);
    int lg = cfg_lg(sel);
    r = '0; r.busy = 1'b1; r.load = 1'b1;
    q.push_back(r);
    for (int rd = 0; rd <= lg; rd++) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (!(ph == 1 && rd == lg)) begin
          for (int st = 0; st < n; st++) begin
            for (int c = 0; c < sc; c++) begin
              r = '0;
              r.busy    = 1'b1;
              r.phase   = ph[0];
              r.parity  = st[0];
              r.step    = 3'(st);
              r.round   = 4'(rd);
              r.step_en = (c == sc - 1);
              q.push_back(r);
            end
          end
        end
      end
    end
    r = '0; r.busy = 1'b1; r.done = 1'b1;
    q.push_back(r);
  endtask

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s sel=%0d t=%0t observed=%h expected=%h", tag, sel, $time, obs, e);
    end
  endtask

  function automatic void clr_counts();
    n_busy = 0; n_sten = 0; n_load = 0; n_done = 0;
  endfunction

  // One clock: drive inputs at the falling edge, compare the displayed state, advance the model.
  task automatic cyc(input logic s, input logic h);
    rec_t e;
    bit   was_idle;
    @(negedge clk);
    start = s;
    hold  = h;
    #1;
    was_idle = (q.size() == 0);
    if (was_idle) begin
      e = '0;
    end else begin
      e = q[0];
      if (e.load || e.done || !h) q.delete(0);
      else e.step_en = 1'b0;
    end
    n_busy += int'(obs.busy);
    n_sten += int'(obs.step_en);
    n_load += int'(obs.load);
    n_done += int'(obs.done);
    chk_rec("cycle", e);
    if (was_idle && s) push_sort();
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() > 0; k++) cyc(1'b0, 1'b0);
    chk("drain_timeout", q.size(), 0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic plain_sort(input int s, input int exp_busy, input int exp_sten);
    sel = s;
    clr_counts();
    cyc(1'b1, 1'b0);
    drain();
    chk("busy_len", n_busy, exp_busy);
    chk("step_en_cnt", n_sten, exp_sten);
    chk("load_cnt", n_load, 1);
    chk("done_cnt", n_done, 1);
  endtask

  function automatic bit front_is(input int rd, input int ph, input int st);
    if (q.size() == 0) return 1'b0;
    return !q[0].load && !q[0].done && (int'(q[0].round) == rd) &&
           (int'(q[0].phase) == ph) && (int'(q[0].step) == st);
  endfunction

  initial begin
    // Reset state of every configuration while rst is asserted.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_rec("reset_state", '0);
    end
    @(negedge clk);
    rst = 1'b1;
    sel = 0;

    plain_sort(0, 22, 20);
    plain_sort(1, 62, 20);
    plain_sort(2, 58, 56);

    // Five-cycle hold during round 1 column step 2.
    begin
      int hc = 0;
      bit h;
      sel = 0;
      clr_counts();
      cyc(1'b1, 1'b0);
      for (int k = 0; k < 200 && q.size() > 0; k++) begin
        h = front_is(1, 1, 2) && (hc < 5);
        if (h) hc++;
        cyc(1'b0, h);
      end
      chk("hold_drain_timeout", q.size(), 0);
      cyc(1'b0, 1'b0);
      chk("hold_cycles", hc, 5);
      chk("hold_busy_len", n_busy, 27);
      chk("hold_step_en_cnt", n_sten, 20);
    end

    // Reset asserted mid-sort during round 1 row, then restart on the first edge after release.
    sel = 0;
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 100 && !front_is(1, 0, 1); k++) cyc(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("busy_before_rst", int'(obs.busy), 1);
    rst = 1'b0;
    #1;
    chk_rec("async_rst", '0);
    q.delete();
    clr_counts();
    #2;
    start = 1'b1;
    rst   = 1'b1;
    push_sort();
    drain();
    chk("post_rst_busy_len", n_busy, 22);
    chk("post_rst_done_cnt", n_done, 1);

    // Continuous start: back-to-back sorts with exactly one IDLE cycle between them.
    sel = 0;
    clr_counts();
    for (int k = 0; k < 60; k++) cyc(1'b1, 1'b0);
    chk("cont_load_cnt", n_load, 3);
    chk("cont_done_cnt", n_done, 2);
    drain();

    // Random start and hold on every configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 300; k++) begin
        cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameter N, default 4: mesh side length in PEs; SHALL be a power of two, at least 2.
REQ-002 Parameter SORT_CYCLES, default 1: clock cycles per compare-exchange step; SHALL be at least 1.
REQ-003 Parameter LOG2N, default 2: log2(N); SHALL be set consistent with N.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  request one full mesh sort; sampled only in IDLE.
REQ-007 i_hold  input  1  stall; freezes sequencing while high.
REQ-008 o_busy  output  1  high in every state except IDLE.
REQ-009 o_load  output  1  high for the single LOAD cycle; drives PE rst_memory (reload initial data).
REQ-010 o_phase  output  1  0 = row phase, 1 = column phase; valid in ROW/COL.
REQ-011 o_parity  output  1  odd/even transposition select = step counter bit 0.
REQ-012 o_step_en  output  1  commit strobe for PE compare-exchange.
REQ-013 o_step  output  LOG2N  current step index within phase, 0..N-1.
REQ-014 o_round  output  4  current shearsort round, 0..LOG2N.
REQ-015 o_done  output  1  high for the single DONE cycle.

Function
REQ-016 States: IDLE, LOAD, ROW, COL, DONE; encoding free.
REQ-017 IDLE -> LOAD on edge where i_start=1; i_start ignored in all other states.
REQ-018 LOAD -> ROW (round 0, step 0, cycle 0) after exactly one cycle; i_hold does not affect LOAD or DONE.
REQ-019 Counters: cyc 0..SORT_CYCLES-1, step 0..N-1, round 0..LOG2N; all cleared on entering LOAD.
REQ-020 In ROW/COL with i_hold=0: cyc increments; at cyc=SORT_CYCLES-1 cyc wraps to 0 and step increments; at step=N-1 with cyc wrap, the phase ends.
REQ-021 ROW phase end: if round=LOG2N -> DONE; else -> COL, same round, step=0.
REQ-022 COL phase end: -> ROW, round+1, step=0.
REQ-023 Resulting sequence: LOG2N+1 row phases interleaved with LOG2N column phases, starting and ending with row; each phase N*SORT_CYCLES non-held cycles.
REQ-024 DONE -> IDLE after one cycle; i_start high in DONE is ignored; new sort requires i_start sampled in IDLE.
REQ-025 o_step_en = 1 iff state is ROW or COL, cyc=SORT_CYCLES-1 and i_hold=0 (the only combinational input-to-output path).
REQ-026 i_hold=1 in ROW/COL: all counters and state frozen, o_step_en=0, other outputs hold value.
REQ-027 o_phase, o_parity, o_step, o_round SHALL be 0 in IDLE, LOAD and DONE.
REQ-028 Unbroken busy duration with no hold: 2 + (2*LOG2N+1)*N*SORT_CYCLES cycles.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, all counters 0 and every output 0, independent of clk.
REQ-030 Reset asserted mid-sort SHALL abort the sort; no o_done is produced; after release the block waits in IDLE for i_start.
REQ-031 First rising edge after rst deasserts SHALL sample i_start normally.

Verification
REQ-032 N=4, SORT_CYCLES=1, one-cycle i_start -> o_load 1 cycle, then 20 ROW/COL cycles in order R,C,R,C,R (4 each), o_done 1 cycle; o_busy high 22 cycles; 20 o_step_en pulses.
REQ-033 N=4, SORT_CYCLES=3 -> o_step_en every third cycle, 20 pulses total, o_busy high 62 cycles; o_parity toggles per step 0,1,0,1 within each phase.
REQ-034 i_hold high 5 cycles during round 1 COL step 2 -> o_step/o_round/o_phase frozen, no o_step_en during hold, o_busy duration extended by exactly 5.
REQ-035 rst pulsed low during round 1 ROW -> outputs 0 asynchronously before next edge, no o_done; subsequent i_start runs a full 22-cycle sort.
REQ-036 i_start held continuously high -> back-to-back sorts separated by exactly one IDLE cycle; i_start pulses during busy and in DONE produce no extra sort.
REQ-037 N=8, SORT_CYCLES=1 -> o_round reaches 3, seven phases of 8 steps, o_busy high 58 cycles.
